// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU/mul-div opcodes, md FSM states, EX register layout.
package ex_pkg;

    localparam int XLEN     = 32;
    localparam int MD_STEPS = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic            valid;
        logic            regWe;
        logic            dMemWe;
        logic            sWD;
        logic [4:0]      wra;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic            sImm;
        alu_op_e         aluOp;
        logic            md;
        md_op_e          mdOp;
    } ex_reg_t;

endpackage

// File: rtl/md_unit.sv
// Iterative unsigned multiply/divide: one shift-add or restoring-subtract step per cycle.
module md_unit
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  md_op_e          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    md_state_e         state_q;
    logic [4:0]        cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q;
    md_op_e            op_q;
    logic [XLEN:0]     sum, trial, diff;
    logic              div_ge;

    // acc holds {hi,lo} for multiply and {remainder,quotient} for divide
    always_comb begin
        sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        trial  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff   = trial - {1'b0, b_q};
        div_ge = (trial >= {1'b0, b_q});
        if (op_q == MD_MUL || op_q == MD_MULHU)
            acc_d = {sum, acc_q[XLEN-1:1]};
        else
            acc_d = {(div_ge ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            op_q    <= MD_MUL;
        end else if (abort_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: if (start_i) begin
                    acc_q   <= {{XLEN{1'b0}}, a_i};
                    b_q     <= b_i;
                    op_q    <= op_i;
                    cnt_q   <= '0;
                    state_q <= MD_BUSY;
                end
                MD_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(MD_STEPS - 1)) state_q <= MD_DONE;
                end
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == MD_BUSY);
    assign done_o = (state_q == MD_DONE);

    always_comb begin
        case (op_q)
            MD_MUL, MD_DIVU:  result_o = acc_q[XLEN-1:0];
            MD_MULHU, MD_REMU: result_o = acc_q[2*XLEN-1:XLEN];
            default:          result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: EX input register, single-cycle ALU and stalling iterative mul/div.
module ex_stage
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_EX_valid,
    input  logic            i_EX_regWe,
    input  logic            i_EX_dMemWe,
    input  logic            i_EX_sWD,
    input  logic [4:0]      i_EX_WRA,
    input  logic [XLEN-1:0] i_EX_rd1,
    input  logic [XLEN-1:0] i_EX_rd2,
    input  logic [XLEN-1:0] i_EX_imm,
    input  logic            i_EX_sImm,
    input  logic [3:0]      i_EX_aluOp,
    input  logic            i_EX_md,
    input  logic [1:0]      i_EX_mdOp,
    input  logic            i_EX_flush,
    output logic            o_EX_stall,
    output logic            o_EX_regWe,
    output logic            o_EX_dMemWe,
    output logic            o_EX_sWD,
    output logic [4:0]      o_EX_WRA,
    output logic [XLEN-1:0] o_EX_aluOut,
    output logic [XLEN-1:0] o_EX_rd2
);

    ex_reg_t         ex_q, ex_d;
    logic            md_busy, md_done, md_start;
    logic [XLEN-1:0] md_result, op_b, alu_res;

    assign o_EX_stall = ex_q.valid & ex_q.md & ~md_done;
    assign md_start   = ex_q.valid & ex_q.md & ~md_busy & ~md_done & ~i_EX_flush;

    always_comb begin
        ex_d = ex_q;
        if (i_EX_flush) begin
            ex_d = '0;
        end else if (!o_EX_stall) begin
            ex_d.valid  = i_EX_valid;
            ex_d.regWe  = i_EX_regWe;
            ex_d.dMemWe = i_EX_dMemWe;
            ex_d.sWD    = i_EX_sWD;
            ex_d.wra    = i_EX_WRA;
            ex_d.rd1    = i_EX_rd1;
            ex_d.rd2    = i_EX_rd2;
            ex_d.imm    = i_EX_imm;
            ex_d.sImm   = i_EX_sImm;
            ex_d.aluOp  = alu_op_e'(i_EX_aluOp);
            ex_d.md     = i_EX_md;
            ex_d.mdOp   = md_op_e'(i_EX_mdOp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign op_b = ex_q.sImm ? ex_q.imm : ex_q.rd2;

    always_comb begin
        case (ex_q.aluOp)
            ALU_ADD:   alu_res = ex_q.rd1 + op_b;
            ALU_SUB:   alu_res = ex_q.rd1 - op_b;
            ALU_AND:   alu_res = ex_q.rd1 & op_b;
            ALU_OR:    alu_res = ex_q.rd1 | op_b;
            ALU_XOR:   alu_res = ex_q.rd1 ^ op_b;
            ALU_SLT:   alu_res = {31'b0, $signed(ex_q.rd1) < $signed(op_b)};
            ALU_SLTU:  alu_res = {31'b0, ex_q.rd1 < op_b};
            ALU_SLL:   alu_res = ex_q.rd1 << op_b[4:0];
            ALU_SRL:   alu_res = ex_q.rd1 >> op_b[4:0];
            ALU_SRA:   alu_res = $unsigned($signed(ex_q.rd1) >>> op_b[4:0]);
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = '0;
        endcase
    end

    md_unit u_md (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .abort_i  (i_EX_flush),
        .op_i     (ex_q.mdOp),
        .a_i      (ex_q.rd1),
        .b_i      (op_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // md instructions show a bubble until their result is ready
    always_comb begin
        o_EX_regWe  = 1'b0;
        o_EX_dMemWe = 1'b0;
        o_EX_sWD    = 1'b0;
        o_EX_WRA    = '0;
        o_EX_aluOut = '0;
        if (ex_q.valid && (!ex_q.md || md_done)) begin
            o_EX_regWe  = ex_q.regWe;
            o_EX_dMemWe = ex_q.dMemWe;
            o_EX_sWD    = ex_q.sWD;
            o_EX_WRA    = ex_q.wra;
            o_EX_aluOut = ex_q.md ? md_result : alu_res;
        end
    end

    assign o_EX_rd2 = ex_q.rd2;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;

    typedef struct {
        logic        valid, regWe, dMemWe, sWD;
        logic [4:0]  wra;
        logic [31:0] rd1, rd2, imm;
        logic        sImm;
        logic [3:0]  aluOp;
        logic        md;
        logic [1:0]  mdOp;
    } ins_t;

    logic        clk = 1'b0, rst;
    logic        i_EX_valid, i_EX_regWe, i_EX_dMemWe, i_EX_sWD, i_EX_sImm, i_EX_md, i_EX_flush;
    logic [4:0]  i_EX_WRA;
    logic [31:0] i_EX_rd1, i_EX_rd2, i_EX_imm;
    logic [3:0]  i_EX_aluOp;
    logic [1:0]  i_EX_mdOp;
    logic        o_EX_stall, o_EX_regWe, o_EX_dMemWe, o_EX_sWD;
    logic [4:0]  o_EX_WRA;
    logic [31:0] o_EX_aluOut, o_EX_rd2;

    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .i_EX_valid(i_EX_valid), .i_EX_regWe(i_EX_regWe), .i_EX_dMemWe(i_EX_dMemWe),
        .i_EX_sWD(i_EX_sWD), .i_EX_WRA(i_EX_WRA), .i_EX_rd1(i_EX_rd1), .i_EX_rd2(i_EX_rd2),
        .i_EX_imm(i_EX_imm), .i_EX_sImm(i_EX_sImm), .i_EX_aluOp(i_EX_aluOp),
        .i_EX_md(i_EX_md), .i_EX_mdOp(i_EX_mdOp), .i_EX_flush(i_EX_flush),
        .o_EX_stall(o_EX_stall), .o_EX_regWe(o_EX_regWe), .o_EX_dMemWe(o_EX_dMemWe),
        .o_EX_sWD(o_EX_sWD), .o_EX_WRA(o_EX_WRA), .o_EX_aluOut(o_EX_aluOut), .o_EX_rd2(o_EX_rd2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] obs();
        return {o_EX_regWe, o_EX_dMemWe, o_EX_sWD, o_EX_WRA, o_EX_aluOut};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [63:0] ext;
        sh  = int'(b[4:0]);
        ext = {{32{a[31]}}, a} >> sh;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return ext[31:0];
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic ins_t mk(input logic [3:0] aluOp, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic sImm, input logic md, input logic [1:0] mdOp);
        ins_t t;
        t.valid = 1'b1; t.regWe = 1'b1; t.dMemWe = 1'b0; t.sWD = 1'b0; t.wra = 5'd3;
        t.rd1 = rd1; t.rd2 = rd2; t.imm = imm; t.sImm = sImm;
        t.aluOp = aluOp; t.md = md; t.mdOp = mdOp;
        return t;
    endfunction

    task automatic set_in(input ins_t t);
        i_EX_valid = t.valid; i_EX_regWe = t.regWe; i_EX_dMemWe = t.dMemWe; i_EX_sWD = t.sWD;
        i_EX_WRA = t.wra; i_EX_rd1 = t.rd1; i_EX_rd2 = t.rd2; i_EX_imm = t.imm;
        i_EX_sImm = t.sImm; i_EX_aluOp = t.aluOp; i_EX_md = t.md; i_EX_mdOp = t.mdOp;
    endtask

    // Called at a negedge; returns at the negedge where the instruction's result is visible.
    task automatic exec(input ins_t t, input string tag);
        logic [31:0] b, res;
        int stalls, bub_bad;
        stalls = 0; bub_bad = 0;
        set_in(t);
        @(posedge clk); @(negedge clk);
        b = t.sImm ? t.imm : t.rd2;
        if (t.valid && t.md) begin
            while (o_EX_stall && stalls < 40) begin
                if (obs() != 40'd0) bub_bad++;
                stalls++;
                @(negedge clk);
            end
            chk({tag, "_lat"}, 64'(stalls), 64'd33);
            chk({tag, "_bub"}, 64'(bub_bad), 64'd0);
            res = ref_md(t.mdOp, t.rd1, b);
        end else begin
            chk({tag, "_stall"}, 64'(o_EX_stall), 64'd0);
            res = ref_alu(t.aluOp, t.rd1, b);
        end
        chk({tag, "_out"}, 64'(obs()), t.valid ? 64'({t.regWe, t.dMemWe, t.sWD, t.wra, res}) : 64'd0);
        chk({tag, "_rd2"}, 64'(o_EX_rd2), 64'(t.rd2));
    endtask

    ins_t idle_t, t;
    int   bad;

    initial begin
        idle_t = mk(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
        idle_t.valid = 1'b0; idle_t.regWe = 1'b0;
        i_EX_flush = 1'b0;
        rst = 1'b1;
        set_in(mk(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 2'd0));
        repeat (3) @(negedge clk);
        chk("rst_stall", 64'(o_EX_stall), 64'd0);
        chk("rst_bub", 64'(obs()), 64'd0);
        set_in(idle_t);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_bub", 64'(obs()), 64'd0);
        chk("post_rst_stall", 64'(o_EX_stall), 64'd0);

        exec(mk(4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 2'd0), "add_ovf");
        chk("add_ovf_k", 64'(o_EX_aluOut), 64'h8000_0000);
        exec(mk(4'd9, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 1'b0, 2'd0), "sra");
        chk("sra_k", 64'(o_EX_aluOut), 64'hF800_0000);
        exec(mk(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 2'd0), "slt");
        chk("slt_k", 64'(o_EX_aluOut), 64'd1);
        exec(mk(4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 2'd0), "sltu");
        chk("sltu_k", 64'(o_EX_aluOut), 64'd0);
        exec(mk(4'd13, 32'h1234, 32'h5678, 32'd0, 1'b0, 1'b0, 2'd0), "undef");
        exec(mk(4'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1, 2'd0), "mul");
        chk("mul_k", 64'(o_EX_aluOut), 64'hFFFF_FFFE);
        chk("mul_we", 64'(o_EX_regWe), 64'd1);
        exec(mk(4'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1, 2'd1), "mulhu");
        chk("mulhu_k", 64'(o_EX_aluOut), 64'd1);
        exec(mk(4'd0, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 2'd2), "divu");
        chk("divu_k", 64'(o_EX_aluOut), 64'd14);
        exec(mk(4'd0, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 2'd3), "remu");
        chk("remu_k", 64'(o_EX_aluOut), 64'd2);
        exec(mk(4'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 2'd2), "divu0");
        chk("divu0_k", 64'(o_EX_aluOut), 64'hFFFF_FFFF);
        exec(mk(4'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 2'd3), "remu0");
        chk("remu0_k", 64'(o_EX_aluOut), 64'd5);

        // flush a divide in its 10th busy cycle
        set_in(mk(4'd0, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 2'd2));
        @(posedge clk); @(negedge clk);
        repeat (10) @(negedge clk);
        chk("flush_pre_stall", 64'(o_EX_stall), 64'd1);
        i_EX_flush = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("flush_stall", 64'(o_EX_stall), 64'd0);
        chk("flush_bub", 64'(obs()), 64'd0);
        i_EX_flush = 1'b0;
        exec(mk(4'd0, 32'd40, 32'd2, 32'd0, 1'b0, 1'b0, 2'd0), "flush_add");
        chk("flush_add_k", 64'(o_EX_aluOut), 64'd42);

        // reset pulse in the 5th busy cycle of a multiply
        set_in(mk(4'd0, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 2'd0));
        @(posedge clk); @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_stall", 64'(o_EX_stall), 64'd0);
        chk("rstmid_bub", 64'(obs()), 64'd0);
        set_in(idle_t);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_EX_regWe || o_EX_stall) bad++;
        end
        chk("rstmid_nowrite", 64'(bad), 64'd0);

        for (int i = 0; i < 150; i++) begin
            t = mk(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 1'($urandom), 1'b0, 2'd0);
            t.valid  = ($urandom_range(0, 7) != 0);
            t.regWe  = 1'($urandom);
            t.dMemWe = 1'($urandom);
            t.sWD    = 1'($urandom);
            t.wra    = 5'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                t.md = 1'b1; t.sImm = 1'b0; t.mdOp = 2'($urandom);
                if ($urandom_range(0, 5) == 0) t.rd2 = 32'd0;
                else if ($urandom_range(0, 2) == 0) t.rd2 = 32'($urandom_range(1, 300));
            end
            exec(t, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
